// File: rtl/d1_dense_ctrl.sv
// Dense-layer sequencer: streams (input, weight) pairs into d1_mul_acc, adds bias with saturation.
// Define D1_DENSE_RELU_EN to clamp negative neuron results to zero.
module d1_dense_ctrl #(
   parameter int unsigned N_IN  = 8,
   parameter int unsigned N_OUT = 4,
   parameter int unsigned DW    = 16,
   localparam int unsigned IAW  = (N_IN > 1) ? $clog2(N_IN) : 1,
   localparam int unsigned WAW  = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
   localparam int unsigned JW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start_i,
   output logic           busy_o,
   output logic           done_o,
   output logic [IAW-1:0] in_addr_o,
   input  logic [DW-1:0]  in_data_i,
   output logic [WAW-1:0] w_addr_o,
   input  logic [DW-1:0]  w_data_i,
   output logic [JW-1:0]  b_addr_o,
   input  logic [DW-1:0]  b_data_i,
   output logic [DW-1:0]  mac_input_o,
   output logic [DW-1:0]  mac_w_o,
   output logic [DW-1:0]  mac_sum_o,
   input  logic [DW-1:0]  mac_output_i,
   output logic           out_valid_o,
   input  logic           out_ready_i,
   output logic [DW-1:0]  out_data_o,
   output logic [JW-1:0]  out_idx_o
);

   typedef enum logic [2:0] {StIdle, StIssue, StDrain, StBias, StOut, StDone} state_e;

   state_e         state_q, state_d;
   logic [IAW-1:0] i_q, i_d;
   logic [JW-1:0]  j_q, j_d;
   logic [DW-1:0]  acc_q, acc_d;
   logic [DW-1:0]  out_data_q, out_data_d;
   logic [JW-1:0]  out_idx_q, out_idx_d;
   logic           drain_q, drain_d;
   logic           dv_q, cap_q;

   logic [DW:0]    bias_sum;
   logic [DW-1:0]  sat_res, bias_res;

   // Sign-extended add; overflow shows up as disagreement of the two top bits.
   assign bias_sum = {acc_q[DW-1], acc_q} + {b_data_i[DW-1], b_data_i};

   always_comb begin
      sat_res = bias_sum[DW-1:0];
      if (bias_sum[DW] != bias_sum[DW-1]) begin
         sat_res = bias_sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end
`ifdef D1_DENSE_RELU_EN
      bias_res = sat_res[DW-1] ? '0 : sat_res;
`else
      bias_res = sat_res;
`endif
   end

   always_comb begin
      state_d    = state_q;
      i_d        = i_q;
      j_d        = j_q;
      acc_d      = acc_q;
      drain_d    = drain_q;
      out_data_d = out_data_q;
      out_idx_d  = out_idx_q;
      if (cap_q) begin
         acc_d = mac_output_i;
      end
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StIssue;
               i_d     = '0;
               j_d     = '0;
               acc_d   = '0;
            end
         end
         StIssue: begin
            if (i_q == IAW'(N_IN - 1)) begin
               state_d = StDrain;
               drain_d = 1'b0;
            end else begin
               i_d = i_q + IAW'(1);
            end
         end
         StDrain: begin
            drain_d = 1'b1;
            if (drain_q) begin
               state_d = StBias;
            end
         end
         StBias: begin
            out_data_d = bias_res;
            out_idx_d  = j_q;
            state_d    = StOut;
         end
         StOut: begin
            if (out_ready_i) begin
               if (j_q == JW'(N_OUT - 1)) begin
                  state_d = StDone;
               end else begin
                  j_d     = j_q + JW'(1);
                  i_d     = '0;
                  acc_d   = '0;
                  state_d = StIssue;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         i_q        <= '0;
         j_q        <= '0;
         acc_q      <= '0;
         drain_q    <= 1'b0;
         dv_q       <= 1'b0;
         cap_q      <= 1'b0;
         out_data_q <= '0;
         out_idx_q  <= '0;
      end else begin
         state_q    <= state_d;
         i_q        <= i_d;
         j_q        <= j_d;
         acc_q      <= acc_d;
         drain_q    <= drain_d;
         dv_q       <= (state_q == StIssue);
         cap_q      <= dv_q;
         out_data_q <= out_data_d;
         out_idx_q  <= out_idx_d;
      end
   end

   assign busy_o      = (state_q != StIdle);
   assign done_o      = (state_q == StDone);
   assign out_valid_o = (state_q == StOut);
   assign out_data_o  = out_data_q;
   assign out_idx_o   = out_idx_q;

   // Addresses hold their last value outside ISSUE; only the data-valid flag gates the MAC.
   assign in_addr_o   = i_q;
   assign w_addr_o    = WAW'(j_q) * WAW'(N_IN) + WAW'(i_q);
   assign b_addr_o    = j_q;

   assign mac_input_o = dv_q ? in_data_i : '0;
   assign mac_w_o     = dv_q ? w_data_i : '0;
   assign mac_sum_o   = acc_q;

endmodule

// File: doc/d1_dense_ctrl.md
Name: d1_dense_ctrl

Overview:
- Initiator/sequencer for the dense-layer multiply-accumulate cell (d1_mul_acc).
- Reads input activations, weights and biases from single-port sync-read memories and streams one (input, weight) pair per cycle into the MAC.
- Feeds the running sum back to the MAC and adds the bias with saturation.
- Emits one Q8.8 result per neuron on a valid/ready output port.

Parameters:
- N_IN, 8: inputs per neuron (>=1).
- N_OUT, 4: neurons per layer (>=1).
- DW, 16: data width, signed Q8.8.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start_i  in  1  start layer; sampled only in IDLE
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse after the last neuron handshakes
- in_addr_o  out  clog2(N_IN)  input memory address
- in_data_i  in  DW  input data, valid 1 cycle after address
- w_addr_o  out  clog2(N_IN*N_OUT)  weight address, equals j*N_IN+i
- w_data_i  in  DW  weight data, valid 1 cycle after address
- b_addr_o  out  clog2(N_OUT)  bias address, equals neuron index j
- b_data_i  in  DW  bias data, valid 1 cycle after address
- mac_input_o  out  DW  to MAC dense_input_i
- mac_w_o  out  DW  to MAC dense_w_i
- mac_sum_o  out  DW  to MAC dense_sum_i; always equals acc
- mac_output_i  in  DW  from MAC dense_output_o
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer ready
- out_data_o  out  DW  neuron result
- out_idx_o  out  clog2(N_OUT)  neuron index of out_data_o

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - All outputs, acc, counters and state are 0; state is IDLE.
  - Reset asserted mid-operation aborts the layer immediately. No out_valid_o or done_o follows.
- MAC timing contract: the multiply is registered and the add is combinational. A pair presented in cycle t appears as mac_output_i = mac_sum_o + product in cycle t+1.
- States: IDLE, ISSUE, DRAIN, BIAS, OUT, DONE.
- IDLE:
  - start_i=1 -> ISSUE; j=0, i=0, acc=0.
  - start_i while busy is ignored.
- ISSUE (N_IN cycles):
  - Drive in_addr_o=i, w_addr_o=j*N_IN+i, b_addr_o=j; i increments each cycle.
  - After i=N_IN-1 -> DRAIN.
- Data-valid flag: the issue flag delayed 1 cycle.
  - When set: mac_input_o=in_data_i and mac_w_o=w_data_i.
  - Otherwise both are 0, so the MAC buffer holds 0.
- Capture flag: the issue flag delayed 2 cycles. When set, acc <= mac_output_i.
- DRAIN (2 cycles): no new addresses; the last product is absorbed into acc at the end of the 2nd cycle -> BIAS.
- BIAS (1 cycle):
  - out_data_o <= sat16(acc + b_data_i), signed.
  - Positive overflow gives 0x7FFF; negative overflow gives 0x8000.
  - out_idx_o <= j -> OUT.
- OUT:
  - out_valid_o=1; out_data_o and out_idx_o are held stable until out_valid_o & out_ready_i.
  - On handshake with j<N_OUT-1: j++, i=0, acc=0 -> ISSUE.
  - On handshake with j=N_OUT-1 -> DONE.
- DONE: done_o=1 for one cycle -> IDLE.
- Latency: start sampled in cycle 0 -> first out_valid_o in cycle N_IN+4.
  - Each later neuron's out_valid_o comes N_IN+4 cycles after the previous handshake.
- N_IN=1: ISSUE lasts 1 cycle; the rest is unchanged.
- acc overflow within the MAC chain follows MAC add semantics; this block does not alter it.

Optional Feature:
- Macro D1_DENSE_RELU_EN.
- Defined: in BIAS, a saturated result with the sign bit set is replaced by 0x0000 before being registered into out_data_o.
- Undefined: the signed saturated value is output unchanged.
- Latency is identical in both builds.

Test Plan:
- Bench wiring: connect the DUT to a real d1_mul_acc and to behavioural sync-read memories.
- Basic layer: N_IN=4, N_OUT=2, inputs all 0x0100, weights all 0x0080, biases 0x0000 and 0x0100 -> out (idx0, 0x0200) and (idx1, 0x0300). First out_valid_o in cycle 8 after start; done_o 1 cycle after the 2nd handshake.
- Bias saturation: inputs 0x0100, weights give acc=0x7000, bias 0x2000 -> out_data 0x7FFF. Bias 0x8000 with acc=0xF000 -> 0x8000.
- Backpressure: out_ready_i low 5 cycles in OUT -> out_valid_o stays high, out_data/out_idx stable, no addresses issued; resumes ISSUE the cycle after the handshake.
- Start while busy: pulse start_i in ISSUE -> no effect; exactly N_OUT results and one done_o.
- Reset mid-ISSUE: deassert rst_n in cycle 3 -> all outputs 0 and state IDLE. A restart gives the same results as the basic layer test.
- ReLU: acc=0xFF00, bias 0 -> 0x0000 with D1_DENSE_RELU_EN, 0xFF00 without.
